// File: rtl/data_receiver_pkg.sv
// data_receiver_pkg: frame constants shared with the transmitter side plus the
// receiver's local FSM state encoding.
//   START_BIT_LEVEL / STOP_BIT_LEVEL / IDLE_LEVEL : serial line levels
//   DEFAULT_DATA_WIDTH / DEFAULT_US_PER_BIT       : default frame geometry
//   rx_state_e                                    : receiver FSM states
package data_receiver_pkg;

    localparam logic START_BIT_LEVEL = 1'b0;
    localparam logic STOP_BIT_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL      = 1'b1;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_US_PER_BIT = 10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/data_receiver_if.sv
// data_receiver_if: serial input side and parallel output side of the receiver.
//   rx, every_us                        : driven by the line / strobe source
//   data, data_valid, frame_error, busy : driven by the receiver
// master = environment side, slave = receiver side.
interface data_receiver_if #(
    parameter int unsigned DATA_WIDTH = data_receiver_pkg::DEFAULT_DATA_WIDTH
);
    logic                  rx;
    logic                  every_us;
    logic [DATA_WIDTH-1:0] data;
    logic                  data_valid;
    logic                  frame_error;
    logic                  busy;

    modport master (
        output rx,
        output every_us,
        input  data,
        input  data_valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  rx,
        input  every_us,
        output data,
        output data_valid,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/data_receiver_rx_sync.sv
// data_receiver_rx_sync: 2-flop synchronizer for an asynchronous serial input
// with falling-edge detection on the synchronized value. Reusable for other
// serial inputs.
//   i_clk, i_rst : clock, async active-high reset
//   i_rx         : asynchronous input line
//   o_rx_s       : synchronized line (2 cycles latency)
//   o_fall       : one-cycle pulse when o_rx_s goes 1 -> 0
module data_receiver_rx_sync #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RESET_LEVEL;
            r_sync <= RESET_LEVEL;
            r_prev <= RESET_LEVEL;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_s = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/data_receiver.sv
// data_receiver: serial frame receiver (1 start bit, DATA_WIDTH data bits LSB
// first, 1 stop bit), bit-timed by a once-per-microsecond strobe.
//   i_clk, i_rst      : system clock, async active-high reset
//   bus.rx            : serial line, idle high, asynchronous
//   bus.every_us      : one-cycle strobe per microsecond
//   bus.data          : last correctly received word
//   bus.data_valid    : one-cycle pulse when data updates
//   bus.frame_error   : one-cycle pulse on a bad stop bit
//   bus.busy          : high while a frame is in progress
module data_receiver
    import data_receiver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned US_PER_BIT = DEFAULT_US_PER_BIT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    data_receiver_if.slave bus
);

    localparam int unsigned TICK_W = (US_PER_BIT > 1) ? $clog2(US_PER_BIT) : 1;
    localparam int unsigned IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TICK_W-1:0] TICK_HALF_LAST = TICK_W'(US_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_FULL_LAST = TICK_W'(US_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST       = IDX_W'(DATA_WIDTH - 1);

    logic w_rx_s;
    logic w_fall;

    data_receiver_rx_sync #(
        .RESET_LEVEL (IDLE_LEVEL)
    ) u_rx_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_rx   (bus.rx),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall)
    );

    rx_state_e             r_state;
    logic [TICK_W-1:0]     r_tick;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_data_valid;
    logic                  r_frame_error;
    logic                  r_busy;

    // Tick counter is zeroed on every state transition, so each state times
    // from its own entry edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_tick        <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_tick <= '0;
                    if (w_fall) begin
                        r_state <= StStart;
                        r_busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (bus.every_us) begin
                        if (r_tick == TICK_HALF_LAST) begin
                            r_tick <= '0;
                            if (w_rx_s == START_BIT_LEVEL) begin
                                r_state <= StData;
                                r_idx   <= '0;
                            end else begin
                                // Start bit gone by mid-bit: treat as a glitch.
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                StData: begin
                    if (bus.every_us) begin
                        if (r_tick == TICK_FULL_LAST) begin
                            r_tick  <= '0;
                            // Right shift: first bit received ends at the LSB.
                            r_shift <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
                            if (r_idx == IDX_LAST) begin
                                r_state <= StStop;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                StStop: begin
                    if (bus.every_us) begin
                        if (r_tick == TICK_FULL_LAST) begin
                            r_tick  <= '0;
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                            if (w_rx_s == STOP_BIT_LEVEL) begin
                                r_data       <= r_shift;
                                r_data_valid <= 1'b1;
                            end else begin
                                r_frame_error <= 1'b1;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data        = r_data;
    assign bus.data_valid  = r_data_valid;
    assign bus.frame_error = r_frame_error;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_data_receiver.sv
// tb_data_receiver: directed bench for data_receiver with default parameters,
// every_us strobed once per 4 clk (one bit = 40 clk).
module tb_data_receiver;

    localparam int CLK_PER_US  = 4;
    localparam int CLK_PER_BIT = CLK_PER_US * 10;

    logic clk;
    logic rst;

    data_receiver_if #(.DATA_WIDTH(8)) bus ();

    data_receiver #(
        .DATA_WIDTH (8),
        .US_PER_BIT (10)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Strobe generator: high for one clk out of every four.
    int us_cnt = 0;
    initial begin
        bus.every_us = 1'b0;
        forever begin
            @(negedge clk);
            bus.every_us = (us_cnt == CLK_PER_US - 1);
            us_cnt = (us_cnt + 1) % CLK_PER_US;
        end
    end

    // Output monitor, sampled on the falling edge.
    int         n_valid = 0;
    int         n_err = 0;
    int         n_both = 0;
    int         n_busy_rise = 0;
    int         busy_len = 0;
    int         last_busy_len = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] valid_log [$];

    always @(negedge clk) begin
        if (bus.data_valid) begin
            n_valid++;
            valid_log.push_back(bus.data);
        end
        if (bus.frame_error) n_err++;
        if (bus.data_valid && bus.frame_error) n_both++;
        if (bus.busy && !prev_busy) begin
            n_busy_rise++;
            busy_len = 0;
        end
        if (bus.busy) busy_len++;
        if (!bus.busy && prev_busy) last_busy_len = busy_len;
        prev_busy = bus.busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (CLK_PER_BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int v0;
    int e0;
    int b0;

    initial begin
        bus.rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, bus.data}, 32'h00);
        chk("rst_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("rst_ferr", {31'd0, bus.frame_error}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        idle(20);

        // Single frame.
        v0 = n_valid; e0 = n_err;
        send_frame(8'hA5, 1'b1);
        idle(20);
        chk("single_cnt", n_valid - v0, 1);
        chk("single_data", {24'd0, bus.data}, 32'hA5);
        chk("single_ferr", n_err - e0, 0);
        chk("single_busy", {31'd0, bus.busy}, 32'd0);
        // 5 + 9*10 = 95 strobes from START entry to the pulse edge.
        chk("single_duration", (last_busy_len >= 377 && last_busy_len <= 380), 1);

        // Start glitch: 3 us low.
        v0 = n_valid; e0 = n_err; b0 = n_busy_rise;
        bus.rx = 1'b0;
        repeat (3 * CLK_PER_US) @(negedge clk);
        idle(CLK_PER_BIT);
        chk("glitch_busy_rose", n_busy_rise - b0, 1);
        chk("glitch_busy_now", {31'd0, bus.busy}, 32'd0);
        chk("glitch_no_valid", n_valid - v0, 0);
        chk("glitch_no_ferr", n_err - e0, 0);
        send_frame(8'h3C, 1'b1);
        idle(20);
        chk("after_glitch_data", {24'd0, bus.data}, 32'h3C);
        chk("after_glitch_cnt", n_valid - v0, 1);

        // Bad stop bit.
        send_frame(8'h11, 1'b1);
        idle(20);
        chk("pre_bad_data", {24'd0, bus.data}, 32'h11);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h7E, 1'b0);
        idle(CLK_PER_BIT);
        chk("bad_ferr_cnt", n_err - e0, 1);
        chk("bad_no_valid", n_valid - v0, 0);
        chk("bad_data_kept", {24'd0, bus.data}, 32'h11);

        // Back-to-back frames.
        valid_log.delete();
        v0 = n_valid;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        chk("b2b_cnt", n_valid - v0, 2);
        if (valid_log.size() == 2) begin
            chk("b2b_first", {24'd0, valid_log[0]}, 32'h00);
            chk("b2b_second", {24'd0, valid_log[1]}, 32'hFF);
        end else begin
            chk("b2b_log_size", valid_log.size(), 2);
        end

        // Reset during data bit 4 of 0x5A.
        v0 = n_valid; e0 = n_err;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bus.rx = 1'b1;
        repeat (CLK_PER_BIT / 2) @(negedge clk);
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_data", {24'd0, bus.data}, 32'h00);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_valid", {31'd0, bus.data_valid}, 32'd0);
        chk("midrst_ferr", {31'd0, bus.frame_error}, 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle(2 * CLK_PER_BIT);
        chk("midrst_no_pulse", (n_valid - v0) + (n_err - e0), 0);
        send_frame(8'h5A, 1'b1);
        idle(20);
        chk("postrst_data", {24'd0, bus.data}, 32'h5A);
        chk("postrst_cnt", n_valid - v0, 1);

        // Stuck-low line after a frame error.
        e0 = n_err;
        send_frame(8'h7E, 1'b0);
        chk("stuck_ferr", n_err - e0, 1);
        v0 = n_valid; e0 = n_err;
        bus.rx = 1'b0;
        repeat (30 * CLK_PER_US) @(negedge clk);
        chk("stuck_no_pulse", (n_valid - v0) + (n_err - e0), 0);
        chk("stuck_busy", {31'd0, bus.busy}, 32'd0);
        idle(CLK_PER_BIT);
        send_frame(8'hC3, 1'b1);
        idle(20);
        chk("stuck_recover_data", {24'd0, bus.data}, 32'hC3);
        chk("stuck_recover_cnt", n_valid - v0, 1);

        chk("exclusive_pulses", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
